// File: rtl/func_proc_if.sv
`default_nettype none
// ============================================================================
// Module   : func_proc_if
// Purpose  : Command/status bundle between a register-interface master and
//            the func_proc_unit engine.
// Signals  : mode/op/op1/op2/start   command from the master
//            busy/done                handshake status
//            result/ov                arithmetic result and signed overflow
//            parity/popcount          bit statistics of {op2,op1}
//            sort_data/sort_cnt/full  keep-smallest sort buffer state
// Revision : 1.0 - initial release
// ============================================================================
interface func_proc_if #(
  parameter int DATA_W     = 8,
  parameter int SORT_DEPTH = 8,
  parameter int CNT_W      = $clog2(SORT_DEPTH + 1),
  parameter int PC_W       = $clog2(2 * DATA_W + 1)
);
  logic [1:0]                   mode;
  logic [1:0]                   op;
  logic [DATA_W-1:0]            op1;
  logic [DATA_W-1:0]            op2;
  logic                         start;
  logic                         busy;
  logic                         done;
  logic [DATA_W-1:0]            result;
  logic                         ov;
  logic                         parity;
  logic [PC_W-1:0]              popcount;
  logic [SORT_DEPTH*DATA_W-1:0] sort_data;
  logic [CNT_W-1:0]             sort_cnt;
  logic                         sort_full;

  modport master (
    output mode, op, op1, op2, start,
    input  busy, done, result, ov, parity, popcount, sort_data, sort_cnt, sort_full
  );

  modport slave (
    input  mode, op, op1, op2, start,
    output busy, done, result, ov, parity, popcount, sort_data, sort_cnt, sort_full
  );
endinterface
`default_nettype wire

// File: rtl/func_proc_unit.sv
`default_nettype none
// ============================================================================
// Module   : func_proc_unit
// Purpose  : Mode-selected function engine: add/sub/sequential signed multiply
//            with overflow, keep-smallest sort buffer, parity/popcount, clear.
// Ports    : clk  - system clock, rising edge
//            rst  - asynchronous active-low reset
//            bus  - func_proc_if.slave command/status bundle
// Revision : 1.0 - initial release
// ============================================================================
module func_proc_unit #(
  parameter int DATA_W     = 8,
  parameter int SORT_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  func_proc_if.slave bus
);
  localparam int CNT_W  = $clog2(SORT_DEPTH + 1);
  localparam int PC_W   = $clog2(2 * DATA_W + 1);
  localparam int STEP_W = $clog2(DATA_W);

  localparam logic [1:0] MODE_ARITH  = 2'd0;
  localparam logic [1:0] MODE_SORT   = 2'd1;
  localparam logic [1:0] MODE_PARITY = 2'd2;
  localparam logic [1:0] OP_ADD      = 2'd0;
  localparam logic [1:0] OP_SUB      = 2'd1;
  localparam logic [1:0] OP_MUL      = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                ov_q, ov_d;
  logic                parity_q, parity_d;
  logic [PC_W-1:0]     popcount_q, popcount_d;
  logic [DATA_W-1:0]   slot_q [SORT_DEPTH];
  logic [DATA_W-1:0]   slot_d [SORT_DEPTH];
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W-1:0] mcand_q, mcand_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic                neg_q, neg_d;
  logic [STEP_W-1:0]   step_q, step_d;

  logic [DATA_W:0]       w_sum, w_diff;
  logic [DATA_W-1:0]     w_mag1, w_mag2;
  logic [2*DATA_W-1:0]   w_acc_nx, w_prod;
  logic [DATA_W:0]       w_prod_hi;
  logic [SORT_DEPTH-1:0] w_gt;
  logic [PC_W-1:0]       w_pc;
  logic [2*DATA_W-1:0]   w_bits;
  logic                  w_full;

  // Sign-extend by one bit so the carry into the extra bit exposes overflow.
  assign w_sum  = {bus.op1[DATA_W-1], bus.op1} + {bus.op2[DATA_W-1], bus.op2};
  assign w_diff = {bus.op1[DATA_W-1], bus.op1} - {bus.op2[DATA_W-1], bus.op2};

  // Magnitudes as unsigned; the most negative value maps to 2^(DATA_W-1).
  assign w_mag1 = bus.op1[DATA_W-1] ? (~bus.op1 + DATA_W'(1)) : bus.op1;
  assign w_mag2 = bus.op2[DATA_W-1] ? (~bus.op2 + DATA_W'(1)) : bus.op2;

  assign w_acc_nx  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign w_prod    = neg_q ? (~w_acc_nx + (2*DATA_W)'(1)) : w_acc_nx;
  // Product fits signed DATA_W only if the top DATA_W+1 bits are all equal.
  assign w_prod_hi = w_prod[2*DATA_W-1:DATA_W-1];

  assign w_bits = {bus.op2, bus.op1};
  assign w_full = (cnt_q == CNT_W'(SORT_DEPTH));

  // Slot k is "above" the new value if it is empty or strictly greater, so
  // equal values land after existing ones. The mask is monotonic in k.
  always_comb begin
    w_gt = '0;
    for (int k = 0; k < SORT_DEPTH; k++) begin
      w_gt[k] = (k >= int'(cnt_q)) || (slot_q[k] > bus.op1);
    end
  end

  always_comb begin
    w_pc = '0;
    for (int i = 0; i < 2 * DATA_W; i++) begin
      w_pc = w_pc + PC_W'(w_bits[i]);
    end
  end

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    ov_d       = ov_q;
    parity_d   = parity_q;
    popcount_d = popcount_q;
    slot_d     = slot_q;
    cnt_d      = cnt_q;
    mcand_d    = mcand_q;
    acc_d      = acc_q;
    mplier_d   = mplier_q;
    neg_d      = neg_q;
    step_d     = step_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_DONE;
          case (bus.mode)
            MODE_ARITH: begin
              case (bus.op)
                OP_ADD: begin
                  result_d = w_sum[DATA_W-1:0];
                  ov_d     = w_sum[DATA_W] ^ w_sum[DATA_W-1];
                end
                OP_SUB: begin
                  result_d = w_diff[DATA_W-1:0];
                  ov_d     = w_diff[DATA_W] ^ w_diff[DATA_W-1];
                end
                OP_MUL: begin
                  mcand_d  = {{DATA_W{1'b0}}, w_mag1};
                  mplier_d = w_mag2;
                  acc_d    = '0;
                  neg_d    = bus.op1[DATA_W-1] ^ bus.op2[DATA_W-1];
                  step_d   = '0;
                  state_d  = ST_MUL;
                end
                default: begin
                  result_d = '0;
                  ov_d     = 1'b0;
                end
              endcase
            end
            MODE_SORT: begin
              // When full, slot SORT_DEPTH-1 simply falls off the top.
              slot_d[0] = w_gt[0] ? bus.op1 : slot_q[0];
              for (int k = 1; k < SORT_DEPTH; k++) begin
                slot_d[k] = w_gt[k-1] ? slot_q[k-1] : (w_gt[k] ? bus.op1 : slot_q[k]);
              end
              if (!w_full) begin
                cnt_d = cnt_q + CNT_W'(1);
              end
            end
            MODE_PARITY: begin
              popcount_d = w_pc;
              parity_d   = ^w_bits;
            end
            default: begin
              for (int k = 0; k < SORT_DEPTH; k++) begin
                slot_d[k] = '1;
              end
              cnt_d      = '0;
              result_d   = '0;
              ov_d       = 1'b0;
              parity_d   = 1'b0;
              popcount_d = '0;
            end
          endcase
        end
      end
      ST_MUL: begin
        acc_d    = w_acc_nx;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        step_d   = step_q + STEP_W'(1);
        // Last partial product: apply the sign and publish in the same cycle.
        if (step_q == STEP_W'(DATA_W - 1)) begin
          result_d = w_prod[DATA_W-1:0];
          ov_d     = ~((&w_prod_hi) | ~(|w_prod_hi));
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      result_q   <= '0;
      ov_q       <= 1'b0;
      parity_q   <= 1'b0;
      popcount_q <= '0;
      cnt_q      <= '0;
      mcand_q    <= '0;
      acc_q      <= '0;
      mplier_q   <= '0;
      neg_q      <= 1'b0;
      step_q     <= '0;
      for (int k = 0; k < SORT_DEPTH; k++) begin
        slot_q[k] <= '1;
      end
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      ov_q       <= ov_d;
      parity_q   <= parity_d;
      popcount_q <= popcount_d;
      cnt_q      <= cnt_d;
      mcand_q    <= mcand_d;
      acc_q      <= acc_d;
      mplier_q   <= mplier_d;
      neg_q      <= neg_d;
      step_q     <= step_d;
      slot_q     <= slot_d;
    end
  end

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.result    = result_q;
  assign bus.ov        = ov_q;
  assign bus.parity    = parity_q;
  assign bus.popcount  = popcount_q;
  assign bus.sort_cnt  = cnt_q;
  assign bus.sort_full = w_full;

  generate
    for (genvar k = 0; k < SORT_DEPTH; k++) begin : g_pack
      assign bus.sort_data[k*DATA_W +: DATA_W] = slot_q[k];
    end
  endgenerate
endmodule
`default_nettype wire

// File: tb/tb_func_proc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_func_proc_unit
// Purpose  : Self-checking bench for func_proc_unit. A behavioural model built
//            from integer arithmetic and a sorted queue predicts every output
//            each cycle; directed literal checks pin the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_func_proc_unit;
  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  func_proc_if #(.DATA_W(DW), .SORT_DEPTH(DEPTH)) bus ();

  func_proc_unit #(.DATA_W(DW), .SORT_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  bit          m_busy   = 1'b0;
  int          m_remain = 0;
  logic [DW-1:0] m_result = '0;
  logic        m_ov     = 1'b0;
  logic        m_par    = 1'b0;
  int          m_pc     = 0;
  int          m_q[$];
  logic [1:0]  p_mode, p_op;
  logic [DW-1:0] p_a, p_b;

  task automatic apply_pending();
    int sa, sb, r, v, idx;
    sa = $signed(p_a);
    sb = $signed(p_b);
    case (p_mode)
      2'd0: begin
        case (p_op)
          2'd0:    r = sa + sb;
          2'd1:    r = sa - sb;
          2'd2:    r = sa * sb;
          default: r = 0;
        endcase
        m_result = r[DW-1:0];
        m_ov     = (r < -(1 << (DW-1))) || (r > (1 << (DW-1)) - 1);
      end
      2'd1: begin
        v   = int'(p_a);
        idx = m_q.size();
        for (int i = m_q.size() - 1; i >= 0; i--) if (m_q[i] > v) idx = i;
        m_q.insert(idx, v);
        if (m_q.size() > DEPTH) void'(m_q.pop_back());
      end
      2'd2: begin
        m_pc  = $countones({p_b, p_a});
        m_par = m_pc[0];
      end
      default: begin
        m_q.delete();
        m_result = '0;
        m_ov     = 1'b0;
        m_par    = 1'b0;
        m_pc     = 0;
      end
    endcase
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 1'b0; m_remain = 0; m_result = '0; m_ov = 1'b0;
      m_par = 1'b0; m_pc = 0; m_q.delete();
    end else if (m_busy) begin
      if (m_remain == 0) m_busy = 1'b0;
      else begin
        m_remain--;
        if (m_remain == 0) apply_pending();
      end
    end else if (bus.start) begin
      p_mode = bus.mode; p_op = bus.op; p_a = bus.op1; p_b = bus.op2;
      m_busy   = 1'b1;
      m_remain = (p_mode == 2'd0 && p_op == 2'd2) ? DW : 0;
      if (m_remain == 0) apply_pending();
    end
  end

  logic [DEPTH*DW-1:0] exp_sd;
  int tmp;
  always @(negedge clk) begin
    for (int k = 0; k < DEPTH; k++) begin
      if (k < m_q.size()) begin
        tmp = m_q[k];
        exp_sd[k*DW +: DW] = tmp[DW-1:0];
      end else begin
        exp_sd[k*DW +: DW] = '1;
      end
    end
    chk("busy", bus.busy, m_busy);
    chk("done", bus.done, m_busy && m_remain == 0);
    chk("result", bus.result, m_result);
    chk("ov", bus.ov, m_ov);
    chk("parity", bus.parity, m_par);
    chk("popcount", bus.popcount, m_pc);
    chk("sort_data", bus.sort_data, exp_sd);
    chk("sort_cnt", bus.sort_cnt, m_q.size());
    chk("sort_full", bus.sort_full, m_q.size() == DEPTH);
  end

  // ---------------- stimulus ----------------
  task automatic cmd(input logic [1:0] md, input logic [1:0] o,
                     input logic [DW-1:0] a, input logic [DW-1:0] b, output int lat);
    @(negedge clk);
    bus.mode = md; bus.op = o; bus.op1 = a; bus.op2 = b; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("done_seen", bus.done, 1'b1);
    @(negedge clk);
  endtask

  int lat;
  int ndone;

  initial begin
    bus.mode = '0; bus.op = '0; bus.op1 = '0; bus.op2 = '0; bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_slots", bus.sort_data, {DEPTH*DW{1'b1}});
    rst = 1'b1;

    cmd(2'd0, 2'd0, 8'd100, 8'd50, lat);
    chk("add_lat", lat, 1);
    chk("add_result", bus.result, 8'h96);
    chk("add_ov", bus.ov, 1'b1);
    cmd(2'd0, 2'd1, 8'h80, 8'd1, lat);
    chk("sub_result", bus.result, 8'h7F);
    chk("sub_ov", bus.ov, 1'b1);

    cmd(2'd0, 2'd2, 8'hF9, 8'd9, lat);
    chk("mul_lat", lat, 9);
    chk("mul_result", bus.result, 8'hC1);
    chk("mul_ov", bus.ov, 1'b0);
    cmd(2'd0, 2'd2, 8'd16, 8'd16, lat);
    chk("mul16_result", bus.result, 8'h00);
    chk("mul16_ov", bus.ov, 1'b1);
    cmd(2'd0, 2'd2, 8'h80, 8'hFF, lat);
    chk("mulmin_ov", bus.ov, 1'b1);
    cmd(2'd0, 2'd3, 8'd5, 8'd5, lat);
    chk("op11_result", bus.result, 8'h00);

    cmd(2'd2, 2'd0, 8'h07, 8'h01, lat);
    chk("pc4", bus.popcount, 4);
    chk("par0", bus.parity, 1'b0);
    cmd(2'd2, 2'd0, 8'hFF, 8'h80, lat);
    chk("pc9", bus.popcount, 9);
    chk("par1", bus.parity, 1'b1);

    cmd(2'd0, 2'd0, 8'd3, 8'd4, lat);
    foreach (m_q[i]) ; // keep model queue untouched
    cmd(2'd1, 2'd0, 8'd5, 8'd0, lat);
    cmd(2'd1, 2'd0, 8'd3, 8'd0, lat);
    cmd(2'd1, 2'd0, 8'd9, 8'd0, lat);
    cmd(2'd1, 2'd0, 8'd3, 8'd0, lat);
    chk("sort4_data", bus.sort_data, 64'hFFFFFFFF_09050303);
    chk("sort4_cnt", bus.sort_cnt, 4);
    chk("sort_keeps_result", bus.result, 8'd7);
    cmd(2'd1, 2'd0, 8'd200, 8'd0, lat);
    cmd(2'd1, 2'd0, 8'd1, 8'd0, lat);
    cmd(2'd1, 2'd0, 8'd7, 8'd0, lat);
    cmd(2'd1, 2'd0, 8'd50, 8'd0, lat);
    chk("sort_full", bus.sort_full, 1'b1);
    cmd(2'd1, 2'd0, 8'd2, 8'd0, lat);
    chk("sort8_data", bus.sort_data, 64'h32090705_03030201);
    chk("sort8_cnt", bus.sort_cnt, 8);

    // start during a multiply must be ignored
    @(negedge clk);
    bus.mode = 2'd0; bus.op = 2'd2; bus.op1 = 8'd3; bus.op2 = 8'd4; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.mode = 2'd1; bus.op1 = 8'd0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.mode = 2'd0;
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("hs_done_count", ndone, 1);
    chk("hs_sort_data", bus.sort_data, 64'h32090705_03030201);
    chk("hs_result", bus.result, 8'd12);

    cmd(2'd3, 2'd0, 8'd0, 8'd0, lat);
    chk("clr_cnt", bus.sort_cnt, 0);
    chk("clr_slots", bus.sort_data, {DEPTH*DW{1'b1}});

    // asynchronous reset in cycle 4 of a multiply
    @(negedge clk);
    bus.mode = 2'd0; bus.op = 2'd2; bus.op1 = 8'd5; bus.op2 = 8'd5; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", bus.busy, 1'b0);
    chk("arst_done", bus.done, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("arst_no_done", ndone, 0);
    cmd(2'd0, 2'd0, 8'd1, 8'd2, lat);
    chk("post_rst_add", bus.result, 8'd3);
    chk("post_rst_lat", lat, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/func_proc_unit.md
Name: func_proc_unit

Overview:
- Parametrised successor to the combinational arith/sort/parity function processor.
- Single engine selected by `mode`, with a start/busy/done handshake for the AXI slave register interface.
- Adds a sequential signed multiplier with overflow detection.
- Adds a keep-smallest sort buffer with occupancy/full status, plus popcount alongside parity.

Parameters:
- DATA_W, 8, operand/result/sort element width (>=4)
- SORT_DEPTH, 8, number of sort buffer slots (>=2)
- CNT_W, $clog2(SORT_DEPTH+1), derived, width of sort_cnt
- PC_W, $clog2(2*DATA_W+1), derived, width of popcount

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- mode  in  2  0=arith, 1=sort insert, 2=parity, 3=clear
- op  in  2  arith op: 00 add, 01 sub, 10 mul, 11 reserved
- op1  in  DATA_W  operand 1 / sort input value
- op2  in  DATA_W  operand 2
- start  in  1  command strobe, accepted only when busy=0
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- result  out  DATA_W  signed arith result, two's complement
- ov  out  1  signed overflow of last arith command
- parity  out  1  XOR of all bits of {op2,op1} at start
- popcount  out  PC_W  count of ones in {op2,op1} at start
- sort_data  out  SORT_DEPTH*DATA_W  slot k at bits [k*DATA_W +: DATA_W]; slot 0 smallest
- sort_cnt  out  CNT_W  number of valid slots, 0..SORT_DEPTH
- sort_full  out  1  sort_cnt==SORT_DEPTH

Behaviour:
- Reset (rst=0, asynchronous):
  - busy, done, result, ov, parity, popcount, sort_cnt, sort_full = 0.
  - All sort slots = all-ones (empty marker).
  - An in-flight multiply is aborted with no done pulse.
- Command acceptance:
  - A command is accepted on a rising clk with start=1 and busy=0.
  - mode, op, op1 and op2 are registered at acceptance; later input changes are ignored until done.
  - start while busy=1 is ignored; no queueing.
- done:
  - Pulses exactly one cycle per accepted command.
  - busy is 1 from the cycle after acceptance through the done cycle, and 0 the cycle after done.
- Outputs hold their values between commands. Only the command's own outputs update (e.g. sort does not touch result or ov).
- Add/sub (mode 0, op 00/01):
  - done 1 cycle after acceptance.
  - result = low DATA_W bits of op1±op2 (wraps).
  - ov=1 iff the signed result exceeds [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Mul (mode 0, op 10):
  - Radix-2 shift-add on operand magnitudes with sign fixed at the end.
  - done exactly DATA_W+1 cycles after acceptance.
  - result = low DATA_W bits of the 2*DATA_W signed product.
  - ov=1 iff the product does not fit in signed DATA_W.
  - -2^(DATA_W-1) × -1 sets ov=1.
- op 11: done after 1 cycle, result=0, ov=0.
- Sort insert (mode 1):
  - done 1 cycle after acceptance.
  - op1 is compared unsigned against all slots in parallel and inserted in ascending order; larger entries shift up one slot.
  - Not full: sort_cnt increments.
  - Full: the slot SORT_DEPTH-1 entry is discarded, so the buffer keeps the SORT_DEPTH smallest values seen; sort_cnt holds.
  - A value equal to existing entries is placed above them (stable).
  - Inserting all-ones is legal and counts as a valid entry.
  - Empty slots always read all-ones.
- Parity (mode 2): done 1 cycle after acceptance; parity and popcount update from the registered {op2,op1}.
- Clear (mode 3):
  - done 1 cycle after acceptance.
  - Sort slots return to all-ones; sort_cnt=0, sort_full=0.
  - result, ov, parity, popcount = 0.
- Simultaneous events: reset wins over everything. start together with done is accepted only if busy has already dropped, so back-to-back commands are possible no sooner than the cycle after done.

Test Plan:
- Add overflow: DATA_W=8, start add op1=100 op2=50 -> done 1 cycle later, result=0x96 (-106), ov=1. Then sub op1=-128 op2=1 -> result=0x7F, ov=1.
- Signed mul:
  - op1=-7 op2=9 -> done exactly 9 cycles after acceptance, result=0xC1 (-63), ov=0.
  - op1=16 op2=16 -> result=0x00, ov=1.
  - op1=-128 op2=-1 -> ov=1.
- Sort fill/overflow, SORT_DEPTH=8: insert 5,3,9,3 -> slots 0..3 = 3,3,5,9, sort_cnt=4, slots 4..7=0xFF. Insert 200,1,7,50 -> sort_full=1. Insert 2 -> slots = 1,2,3,3,5,7,9,50, 200 dropped, sort_cnt=8.
- Parity/popcount: op1=0x07 op2=0x01 -> popcount=4, parity=0. op1=0xFF op2=0x80 -> popcount=9, parity=1.
- Handshake: pulse start during a multiply with mode=1 -> ignored, sort unchanged, exactly one done. Issue clear after a full buffer -> sort_cnt=0, all slots 0xFF.
- Reset mid-operation: assert rst at cycle 4 of a multiply -> busy=0 and done=0 immediately (asynchronous), no done after release. The next add command completes normally.
